// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: field widths, immediate-format encodings
// and the ID/EX control bundle.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int NREGS      = 32;
   localparam int REG_ADDR_W = 5;
   localparam int IMM_SRC_W  = 2;
   localparam int ALU_CTRL_W = 3;

   typedef enum logic [IMM_SRC_W-1:0] {
      IMM_I    = 2'b00,
      IMM_S    = 2'b01,
      IMM_B    = 2'b10,
      IMM_NONE = 2'b11
   } imm_src_t;

   typedef struct packed {
      logic                  regwrite;
      logic                  alusrc;
      logic                  memwrite;
      logic                  resultsrc;
      logic                  branch;
      logic [ALU_CTRL_W-1:0] alucontrol;
   } ctrl_t;

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one write port, x0 hardwired to zero, asynchronous active-low clear.
module register_file #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   // x0 has no storage; only entries 1..NREGS-1 exist
   logic [XLEN-1:0] regs_reg [1:NREGS-1];

   generate
      for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               regs_reg[gi] <= '0;
            end else if (we && (wa == AW'(gi))) begin
               regs_reg[gi] <= wd;
            end
         end
      end
   endgenerate

   always_comb begin
      rd1 = '0;
      if (ra1 != '0) begin
         rd1 = (we && (wa == ra1)) ? wd : regs_reg[ra1];
      end
   end

   always_comb begin
      rd2 = '0;
      if (ra2 != '0) begin
         rd2 = (we && (wa == ra2)) ? wd : regs_reg[ra2];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: instruction field slicing, register read, immediate
// extension and the ID/EX pipeline register with stall/flush.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [31:0]                      InstrD,
   input  logic [XLEN-1:0]                  PCD,
   input  logic [XLEN-1:0]                  PCPlus4D,
   input  logic                             ValidD,
   output logic [6:0]                       Op,
   output logic [2:0]                       funct3,
   output logic [6:0]                       funct7,
   input  logic                             RegWriteD,
   input  logic                             ALUSrcD,
   input  logic                             MemWriteD,
   input  logic                             ResultSrcD,
   input  logic                             BranchD,
   input  logic [riscv_pkg::IMM_SRC_W-1:0]  ImmSrcD,
   input  logic [riscv_pkg::ALU_CTRL_W-1:0] ALUControlD,
   input  logic                             RegWriteW,
   input  logic [4:0]                       RDW,
   input  logic [XLEN-1:0]                  ResultW,
   input  logic                             FlushE,
   input  logic                             StallE,
   output logic                             RegWriteE,
   output logic                             ALUSrcE,
   output logic                             MemWriteE,
   output logic                             ResultSrcE,
   output logic                             BranchE,
   output logic [riscv_pkg::ALU_CTRL_W-1:0] ALUControlE,
   output logic [XLEN-1:0]                  RD1E,
   output logic [XLEN-1:0]                  RD2E,
   output logic [XLEN-1:0]                  ImmExtE,
   output logic [4:0]                       RS1E,
   output logic [4:0]                       RS2E,
   output logic [4:0]                       RDE,
   output logic [XLEN-1:0]                  PCE,
   output logic [XLEN-1:0]                  PCPlus4E,
   output logic                             ValidE
);

   import riscv_pkg::*;

   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] rd1, rd2, imm_ext;
   ctrl_t           ctrl_d;

   assign Op     = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign funct7 = InstrD[31:25];
   assign rs1    = InstrD[19:15];
   assign rs2    = InstrD[24:20];
   assign rd     = InstrD[11:7];

   assign ctrl_d = '{regwrite:   RegWriteD,
                     alusrc:     ALUSrcD,
                     memwrite:   MemWriteD,
                     resultsrc:  ResultSrcD,
                     branch:     BranchD,
                     alucontrol: ALUControlD};

   register_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_regfile (
      .clk (clk),
      .rst (rst),
      .we  (RegWriteW),
      .wa  (RDW),
      .wd  (ResultW),
      .ra1 (rs1),
      .ra2 (rs2),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   always_comb begin
      imm_ext = '0;
      case (imm_src_t'(ImmSrcD))
         IMM_I:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
         IMM_S:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm_ext = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                             InstrD[30:25], InstrD[11:8], 1'b0};
         default: imm_ext = '0;
      endcase
   end

   // ID/EX register
   ctrl_t           ctrl_reg, ctrl_next;
   logic [XLEN-1:0] rd1_reg, rd1_next, rd2_reg, rd2_next, imm_reg, imm_next;
   logic [XLEN-1:0] pc_reg, pc_next, pc4_reg, pc4_next;
   logic [4:0]      rs1_reg, rs1_next, rs2_reg, rs2_next, rd_reg, rd_next;
   logic            valid_reg, valid_next;

   always_comb begin
      ctrl_next  = ctrl_reg;
      rd1_next   = rd1_reg;
      rd2_next   = rd2_reg;
      imm_next   = imm_reg;
      pc_next    = pc_reg;
      pc4_next   = pc4_reg;
      rs1_next   = rs1_reg;
      rs2_next   = rs2_reg;
      rd_next    = rd_reg;
      valid_next = valid_reg;
      // Flush beats stall; an empty IF/ID slot becomes a bubble unless stalled
      if (FlushE || (!StallE && !ValidD)) begin
         ctrl_next  = '0;
         rd1_next   = '0;
         rd2_next   = '0;
         imm_next   = '0;
         pc_next    = '0;
         pc4_next   = '0;
         rs1_next   = '0;
         rs2_next   = '0;
         rd_next    = '0;
         valid_next = 1'b0;
      end else if (!StallE) begin
         ctrl_next  = ctrl_d;
         rd1_next   = rd1;
         rd2_next   = rd2;
         imm_next   = imm_ext;
         pc_next    = PCD;
         pc4_next   = PCPlus4D;
         rs1_next   = rs1;
         rs2_next   = rs2;
         rd_next    = rd;
         valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_reg  <= '0;
         rd1_reg   <= '0;
         rd2_reg   <= '0;
         imm_reg   <= '0;
         pc_reg    <= '0;
         pc4_reg   <= '0;
         rs1_reg   <= '0;
         rs2_reg   <= '0;
         rd_reg    <= '0;
         valid_reg <= 1'b0;
      end else begin
         ctrl_reg  <= ctrl_next;
         rd1_reg   <= rd1_next;
         rd2_reg   <= rd2_next;
         imm_reg   <= imm_next;
         pc_reg    <= pc_next;
         pc4_reg   <= pc4_next;
         rs1_reg   <= rs1_next;
         rs2_reg   <= rs2_next;
         rd_reg    <= rd_next;
         valid_reg <= valid_next;
      end
   end

   assign RegWriteE   = ctrl_reg.regwrite;
   assign ALUSrcE     = ctrl_reg.alusrc;
   assign MemWriteE   = ctrl_reg.memwrite;
   assign ResultSrcE  = ctrl_reg.resultsrc;
   assign BranchE     = ctrl_reg.branch;
   assign ALUControlE = ctrl_reg.alucontrol;
   assign RD1E        = rd1_reg;
   assign RD2E        = rd2_reg;
   assign ImmExtE     = imm_reg;
   assign RS1E        = rs1_reg;
   assign RS2E        = rs2_reg;
   assign RDE         = rd_reg;
   assign PCE         = pc_reg;
   assign PCPlus4E    = pc4_reg;
   assign ValidE      = valid_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver queues hand-computed ID/EX
// contents per capture, a negedge monitor pops and compares them.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD;
   logic [6:0]  Op, funct7;
   logic [2:0]  funct3;
   logic        RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD;
   logic [1:0]  ImmSrcD;
   logic [2:0]  ALUControlD;
   logic        RegWriteW;
   logic [4:0]  RDW;
   logic [31:0] ResultW;
   logic        FlushE, StallE;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  RS1E, RS2E, RDE;
   logic        ValidE;

   typedef struct packed {
      logic        regw, alusrc, memw, ressrc, branch;
      logic [2:0]  aluc;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pc, pc4;
      logic        valid;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_pass = 0;
   int    n_total = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .Op(Op), .funct3(funct3), .funct7(funct7),
      .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD),
      .ResultSrcD(ResultSrcD), .BranchD(BranchD), .ImmSrcD(ImmSrcD),
      .ALUControlD(ALUControlD), .RegWriteW(RegWriteW), .RDW(RDW),
      .ResultW(ResultW), .FlushE(FlushE), .StallE(StallE),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RS1E(RS1E), .RS2E(RS2E),
      .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E), .ValidE(ValidE)
   );

   function automatic exp_t actual();
      return '{RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E, ValidE};
   endfunction

   // ctl = {regwrite, alusrc, memwrite, resultsrc, branch}
   function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [4:0] ctl, input logic [2:0] aluc,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm);
      return '{ctl[4], ctl[3], ctl[2], ctl[1], ctl[0], aluc, rd1, rd2, imm,
               instr[19:15], instr[24:20], instr[11:7], pc, pc + 32'd4, 1'b1};
   endfunction

   task automatic check_e(input string name, input exp_t act, input exp_t exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic set_d(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [4:0] ctl, input logic [2:0] aluc,
                        input logic [1:0] imm_src, input logic valid);
      InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
      {RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD} = ctl;
      ALUControlD = aluc; ImmSrcD = imm_src; ValidD = valid;
   endtask

   task automatic wb(input logic we, input logic [4:0] rdw, input logic [31:0] res);
      RegWriteW = we; RDW = rdw; ResultW = res;
   endtask

   // Called right after a negedge: one capture edge, queue its expectation
   task automatic cycle(input string name, input exp_t e);
      @(posedge clk);
      exp_q.push_back(e);
      name_q.push_back(name);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         check_e(n, actual(), e);
         $display("txn %-12s E=%h", n, actual());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e9;
      rst = 1'b1;
      set_d(32'h0, 32'h0, 5'b0, 3'b0, 2'b0, 1'b0);
      wb(1'b0, 5'd0, 32'h0);
      FlushE = 1'b0; StallE = 1'b0;
      #1 rst = 1'b0;
      @(negedge clk);
      check_e("reset_clear", actual(), '0);
      @(negedge clk);
      rst = 1'b1;

      set_d(32'h00500093, 32'h100, 5'b11000, 3'b000, 2'b00, 1'b1);
      cycle("addi", mk(32'h00500093, 32'h100, 5'b11000, 3'b000, 32'h0, 32'h0, 32'h5));

      set_d(32'h00018233, 32'h104, 5'b10000, 3'b000, 2'b00, 1'b1);
      wb(1'b1, 5'd3, 32'hDEADBEEF);
      cycle("wb_bypass", mk(32'h00018233, 32'h104, 5'b10000, 3'b000, 32'hDEADBEEF, 32'h0, 32'h0));
      wb(1'b0, 5'd0, 32'h0);

      set_d(32'h01018313, 32'h108, 5'b11000, 3'b000, 2'b00, 1'b1);
      cycle("x3_readback", mk(32'h01018313, 32'h108, 5'b11000, 3'b000, 32'hDEADBEEF, 32'h0, 32'h10));

      set_d(32'h00000033, 32'h10C, 5'b10000, 3'b000, 2'b00, 1'b1);
      wb(1'b1, 5'd0, 32'h1234);
      cycle("x0_bypass", mk(32'h00000033, 32'h10C, 5'b10000, 3'b000, 32'h0, 32'h0, 32'h0));
      wb(1'b1, 5'd5, 32'h0000A5A5);
      cycle("x0_read", mk(32'h00000033, 32'h10C, 5'b10000, 3'b000, 32'h0, 32'h0, 32'h0));
      wb(1'b0, 5'd0, 32'h0);

      set_d(32'hFE112E23, 32'h110, 5'b01100, 3'b000, 2'b01, 1'b1);
      #1 check_w("fields_sw", {15'h0, Op, funct3, funct7}, {15'h0, 7'h23, 3'd2, 7'h7F});
      cycle("sw_imm", mk(32'hFE112E23, 32'h110, 5'b01100, 3'b000, 32'h0, 32'h0, 32'hFFFFFFFC));

      set_d(32'hFE000CE3, 32'h114, 5'b00001, 3'b001, 2'b10, 1'b1);
      cycle("beq_imm", mk(32'hFE000CE3, 32'h114, 5'b00001, 3'b001, 32'h0, 32'h0, 32'hFFFFFFF8));

      set_d(32'h003283B3, 32'h118, 5'b10010, 3'b010, 2'b11, 1'b1);
      e9 = mk(32'h003283B3, 32'h118, 5'b10010, 3'b010, 32'h0000A5A5, 32'hDEADBEEF, 32'h0);
      cycle("add_x5_x3", e9);

      StallE = 1'b1;
      set_d(32'hFE000CE3, 32'h11C, 5'b00001, 3'b001, 2'b10, 1'b1);
      cycle("stall1", e9);
      set_d(32'hFE112E23, 32'h120, 5'b01100, 3'b000, 2'b01, 1'b0);
      cycle("stall2", e9);
      FlushE = 1'b1;
      set_d(32'h00500093, 32'h124, 5'b11000, 3'b000, 2'b00, 1'b1);
      cycle("flush_stall", '0);
      FlushE = 1'b0; StallE = 1'b0;

      set_d(32'h00500093, 32'h128, 5'b11000, 3'b000, 2'b00, 1'b0);
      cycle("invalid_d", '0);

      set_d(32'hFFF28413, 32'h12C, 5'b11000, 3'b000, 2'b00, 1'b1);
      cycle("addi_neg", mk(32'hFFF28413, 32'h12C, 5'b11000, 3'b000, 32'h0000A5A5, 32'h0, 32'hFFFFFFFF));

      // Asynchronous clear between edges
      #2 rst = 1'b0;
      #1 check_e("async_rst", actual(), '0);
      @(negedge clk);
      rst = 1'b1;
      cycle("x5_after_rst", mk(32'hFFF28413, 32'h12C, 5'b11000, 3'b000, 32'h0, 32'h0, 32'hFFFFFFFF));

      @(negedge clk);
      check_w("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
